// File: rtl/alu_popcount_seq_pkg.sv
// Shared definitions for the popcount sequencer: ALU opcodes and FSM states.
// Opcodes match the shared ALU decoder; states fit in 3 bits.
package alu_popcount_seq_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TEST = 3'd1,
        ST_DEC  = 3'd2,
        ST_MASK = 3'd3,
        ST_INC  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/alu_popcount_seq.sv
// Popcount sequencer: Kernighan loop x &= x-1 driven through an external shared ALU.
// Latency: done in cycle 4*N+2 after start (N = popcount), plus one cycle per denied grant.
// Backpressure: alu_gnt low freezes state, datapath regs and ALU outputs; start ignored while busy.
module alu_popcount_seq
    import alu_popcount_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] result_q, result_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy     = (state_q != ST_IDLE);
        done     = 1'b0;
        alu_req  = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = operand;
                    cnt_d   = '0;
                    state_d = ST_TEST;
                end
            end
            ST_TEST: begin
                alu_req  = 1'b1;
                alu_a    = x_q;
                alu_ctrl = ALU_OR;
                if (alu_gnt) begin
                    if (alu_zero) begin
                        // Load on entry so result is already valid while done is high.
                        result_d = cnt_q;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_DEC;
                    end
                end
            end
            ST_DEC: begin
                alu_req  = 1'b1;
                alu_a    = x_q;
                alu_b    = ONE;
                alu_ctrl = ALU_SUB;
                if (alu_gnt) begin
                    t_d     = alu_y;
                    state_d = ST_MASK;
                end
            end
            ST_MASK: begin
                alu_req  = 1'b1;
                alu_a    = x_q;
                alu_b    = t_q;
                alu_ctrl = ALU_AND;
                if (alu_gnt) begin
                    x_d     = alu_y;
                    state_d = ST_INC;
                end
            end
            ST_INC: begin
                alu_req  = 1'b1;
                alu_a    = {{(WIDTH-CNT_W){1'b0}}, cnt_q};
                alu_b    = ONE;
                alu_ctrl = ALU_ADD;
                if (alu_gnt) begin
                    cnt_d   = alu_y[CNT_W-1:0];
                    state_d = ST_TEST;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign result = result_q;

endmodule
